// File: rtl/ksa_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ksa_engine
//  Purpose  : RC4 key-scheduling engine. It fills a single-port S-array RAM
//             with the identity permutation, then optionally runs the KSA
//             shuffle. Optional cycle counter: KSA_CYCLE_COUNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ksa_engine #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic                   ram_wren,
`ifdef KSA_CYCLE_COUNT_EN
    output logic [31:0]            cycle_count,
`endif
    input  logic [DATA_W-1:0]      ram_rdata
);

    localparam int                  C_KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0]   C_I_LAST    = '1;
    localparam logic [C_KIDX_W-1:0] C_KIDX_LAST = C_KIDX_W'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_RD_I   = 4'd2,
        S_WAIT_I = 4'd3,
        S_CALC_J = 4'd4,
        S_RD_J   = 4'd5,
        S_WAIT_J = 4'd6,
        S_WR_I   = 4'd7,
        S_WR_J   = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDR_W-1:0]        r_i;
    logic [ADDR_W-1:0]        r_j;
    logic [DATA_W-1:0]        r_si;
    logic [DATA_W-1:0]        r_sj;
    logic [C_KIDX_W-1:0]      r_kidx;
    logic                     r_mode;
    logic [8*KEY_BYTES-1:0]   r_key;
    logic [7:0]               w_key_byte;
    logic [ADDR_W-1:0]        w_j_next;
    logic                     w_accept;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done     = (r_state == S_DONE);

    // Byte 0 of the key sits in the most significant byte lane.
    always_comb begin
        w_key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (r_kidx == C_KIDX_W'(k)) begin
                w_key_byte = r_key[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

    assign w_j_next = r_j + r_si[ADDR_W-1:0] + ADDR_W'(w_key_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_kidx  <= '0;
            r_mode  <= 1'b0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mode <= mode;
                r_key  <= key;
                r_i    <= '0;
                r_j    <= '0;
                r_kidx <= '0;
            end else begin
                case (r_state)
                    S_INIT:   r_i  <= r_i + ADDR_W'(1);
                    S_WAIT_I: r_si <= ram_rdata;
                    S_CALC_J: r_j  <= w_j_next;
                    S_WAIT_J: r_sj <= ram_rdata;
                    S_WR_J: begin
                        r_i    <= r_i + ADDR_W'(1);
                        r_kidx <= (r_kidx == C_KIDX_LAST) ? '0 : r_kidx + C_KIDX_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM outputs decode straight from state so an async reset drops ram_wren at once.
    always_comb begin
        w_state_next = r_state;
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_wren     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_next = S_INIT;
            end
            S_INIT: begin
                ram_addr  = r_i;
                ram_wdata = DATA_W'(r_i);
                ram_wren  = 1'b1;
                if (r_i == C_I_LAST) w_state_next = r_mode ? S_RD_I : S_DONE;
            end
            S_RD_I: begin
                ram_addr     = r_i;
                w_state_next = S_WAIT_I;
            end
            S_WAIT_I: w_state_next = S_CALC_J;
            S_CALC_J: w_state_next = S_RD_J;
            S_RD_J: begin
                ram_addr     = r_j;
                w_state_next = S_WAIT_J;
            end
            S_WAIT_J: w_state_next = S_WR_I;
            S_WR_I: begin
                ram_addr     = r_i;
                ram_wdata    = r_sj;
                ram_wren     = 1'b1;
                w_state_next = S_WR_J;
            end
            S_WR_J: begin
                ram_addr     = r_j;
                ram_wdata    = r_si;
                ram_wren     = 1'b1;
                w_state_next = (r_i == C_I_LAST) ? S_DONE : S_RD_I;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef KSA_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_count <= '0;
        end else if (w_accept) begin
            r_cycle_count <= '0;
        end else if (busy && (r_cycle_count != 32'hFFFF_FFFF)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire
